// File: rtl/sram_port0_arbiter_if.sv
// Bundle of the signals between the port-0 arbiter, its two requesters and
// SRAM port 0 of the wrapper. The "slave" modport is the arbiter's view
// (it serves the requesters and drives the SRAM); "master" is the view of
// everything around it (requesters plus the SRAM macro).
interface sram_port0_arbiter_if #(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    // Requester 0 command and response
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [NUM_WMASKS-1:0] req0_wmask;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  resp0_valid;
    logic [DATA_WIDTH-1:0] resp0_rdata;

    // Requester 1 command and response
    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [NUM_WMASKS-1:0] req1_wmask;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  resp1_valid;
    logic [DATA_WIDTH-1:0] resp1_rdata;

    // SRAM port 0 (active-low chip select and write enable)
    logic                  soc_csb0;
    logic                  soc_web0;
    logic [NUM_WMASKS-1:0] soc_wmask0;
    logic [ADDR_WIDTH-1:0] soc_addr0;
    logic [DATA_WIDTH-1:0] soc_din0;
    logic [DATA_WIDTH-1:0] soc_dout0;

    modport slave (
        input  req0_valid, req0_we, req0_wmask, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_rdata,
        input  req1_valid, req1_we, req1_wmask, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_rdata,
        output soc_csb0, soc_web0, soc_wmask0, soc_addr0, soc_din0,
        input  soc_dout0
    );

    modport master (
        output req0_valid, req0_we, req0_wmask, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_rdata,
        output req1_valid, req1_we, req1_wmask, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_rdata,
        input  soc_csb0, soc_web0, soc_wmask0, soc_addr0, soc_din0,
        output soc_dout0
    );
endinterface

// File: rtl/sram_port0_arbiter.sv
// Two-requester arbiter for port 0 of the banked SoC SRAM wrapper.
// One command is granted per cycle (round-robin or fixed priority) and driven
// straight onto the SRAM pins in the same cycle. A two-stage pipeline tracks
// who issued each command and returns a one-cycle response pulse, carrying
// the captured read data, two cycles after acceptance.
module sram_port0_arbiter #(
    parameter int NUM_WMASKS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int ROUND_ROBIN = 1
) (
    input logic                 soc_clk,
    input logic                 soc_rst,
    sram_port0_arbiter_if.slave bus
);

    // Arbitration result for the current cycle
    logic w_grant0;
    logic w_grant1;
    logic w_grant_any;
    logic w_grant_we;

    // Requester that won the most recent grant (0 or 1)
    logic r_last_grant;

    // Stage 1: command accepted in the previous cycle
    logic r_s1_valid;
    logic r_s1_id;
    logic r_s1_we;

    // Stage 2: registered responses
    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic [DATA_WIDTH-1:0] r_resp0_rdata;
    logic [DATA_WIDTH-1:0] r_resp1_rdata;

    // Pick at most one requester; on contention either alternate or favour req0
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            if (ROUND_ROBIN != 0) begin
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = 1'b1;
            end
        end else begin
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid;
        end
    end

    assign w_grant_any = w_grant0 | w_grant1;
    assign w_grant_we  = w_grant1 ? bus.req1_we : bus.req0_we;

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    // Drive the SRAM pins from the granted requester, or park them when idle
    always_comb begin
        bus.soc_csb0   = 1'b1;
        bus.soc_web0   = 1'b1;
        bus.soc_wmask0 = '0;
        bus.soc_addr0  = '0;
        bus.soc_din0   = '0;
        if (w_grant0) begin
            bus.soc_csb0   = 1'b0;
            bus.soc_web0   = ~bus.req0_we;
            bus.soc_wmask0 = bus.req0_wmask;
            bus.soc_addr0  = bus.req0_addr;
            bus.soc_din0   = bus.req0_wdata;
        end else if (w_grant1) begin
            bus.soc_csb0   = 1'b0;
            bus.soc_web0   = ~bus.req1_we;
            bus.soc_wmask0 = bus.req1_wmask;
            bus.soc_addr0  = bus.req1_addr;
            bus.soc_din0   = bus.req1_wdata;
        end
    end

    // Remember the last winner and record the accepted command in stage 1
    always_ff @(posedge soc_clk or posedge soc_rst) begin
        if (soc_rst) begin
            r_last_grant <= 1'b1;
            r_s1_valid   <= 1'b0;
            r_s1_id      <= 1'b0;
            r_s1_we      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_grant_any) begin
                r_last_grant <= w_grant1;
            end
            r_s1_valid <= w_grant_any;
            r_s1_id    <= w_grant1;
            r_s1_we    <= w_grant_we;
        end
    end

    // Turn stage 1 into a response pulse; reads also capture the SRAM output
    always_ff @(posedge soc_clk or posedge soc_rst) begin
        if (soc_rst) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_rdata <= '0;
            r_resp1_rdata <= '0;
        end else begin
            r_resp0_valid <= r_s1_valid & ~r_s1_id;
            r_resp1_valid <= r_s1_valid &  r_s1_id;
            if (r_s1_valid && !r_s1_we) begin
                if (r_s1_id) begin
                    r_resp1_rdata <= bus.soc_dout0;
                end else begin
                    r_resp0_rdata <= bus.soc_dout0;
                end
            end
        end
    end

    assign bus.resp0_valid = r_resp0_valid;
    assign bus.resp1_valid = r_resp1_valid;
    assign bus.resp0_rdata = r_resp0_rdata;
    assign bus.resp1_rdata = r_resp1_rdata;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: a round-robin instance (dut_a) checked cycle
// by cycle against a queue-based reference model, and a fixed-priority
// instance (dut_b) checked against hand-derived expectations. Each DUT sees a
// behavioural synchronous SRAM (read data valid the cycle after the command).
`timescale 1ns/1ps
module tb_sram_port0_arbiter;
    localparam int NW    = 4;
    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 1 << AW;

    logic soc_clk = 1'b0;
    logic soc_rst = 1'b1;
    always #5 soc_clk = ~soc_clk;

    sram_port0_arbiter_if #(.NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
    sram_port0_arbiter_if #(.NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

    sram_port0_arbiter #(.NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROUND_ROBIN(1)) dut_a (
        .soc_clk (soc_clk),
        .soc_rst (soc_rst),
        .bus     (ifa)
    );

    sram_port0_arbiter #(.NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROUND_ROBIN(0)) dut_b (
        .soc_clk (soc_clk),
        .soc_rst (soc_rst),
        .bus     (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Power-on contents of both SRAMs; two words are fixed for directed tests
    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 'h005) return 32'hDEADBEEF;
        if (a == 'h200) return 32'hAAAAAAAA;
        return (32'(a) * 32'h9E3779B1) ^ 32'h0F0F0F0F;
    endfunction

    // Behavioural SRAM models: contents loaded on the first clock edge
    logic [DW-1:0] sram_a [0:DEPTH-1];
    logic [DW-1:0] sram_b [0:DEPTH-1];
    bit loaded_a = 1'b0;
    bit loaded_b = 1'b0;

    always @(posedge soc_clk) begin
        if (!loaded_a) begin
            for (int i = 0; i < DEPTH; i++) sram_a[i] <= init_word(i);
            loaded_a <= 1'b1;
        end else if (!ifa.soc_csb0) begin
            if (!ifa.soc_web0) begin
                for (int b = 0; b < NW; b++)
                    if (ifa.soc_wmask0[b]) sram_a[ifa.soc_addr0][8*b +: 8] <= ifa.soc_din0[8*b +: 8];
            end else begin
                ifa.soc_dout0 <= sram_a[ifa.soc_addr0];
            end
        end
    end

    always @(posedge soc_clk) begin
        if (!loaded_b) begin
            for (int i = 0; i < DEPTH; i++) sram_b[i] <= init_word(i);
            loaded_b <= 1'b1;
        end else if (!ifb.soc_csb0) begin
            if (!ifb.soc_web0) begin
                for (int b = 0; b < NW; b++)
                    if (ifb.soc_wmask0[b]) sram_b[ifb.soc_addr0][8*b +: 8] <= ifb.soc_din0[8*b +: 8];
            end else begin
                ifb.soc_dout0 <= sram_b[ifb.soc_addr0];
            end
        end
    end

    // ---------------- reference model for dut_a ----------------
    typedef struct {
        int            due;
        bit            id;
        bit            we;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         pq[$];
    logic [DW-1:0] shadow [0:DEPTH-1];
    int            m_last;
    logic [DW-1:0] m_rd0, m_rd1;
    int            cyc = 0;
    logic [1:0]    obs_rdy;
    logic [1:0]    obs_resp;

    task automatic idle_a();
        ifa.req0_valid = 1'b0;
        ifa.req1_valid = 1'b0;
        ifa.req0_we    = 1'($urandom);
        ifa.req1_we    = 1'($urandom);
        ifa.req0_wmask = 4'($urandom);
        ifa.req1_wmask = 4'($urandom);
        ifa.req0_addr  = 11'($urandom);
        ifa.req1_addr  = 11'($urandom);
        ifa.req0_wdata = $urandom;
        ifa.req1_wdata = $urandom;
    endtask

    task automatic drive_a(input bit port, input bit we, input logic [NW-1:0] m,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            ifa.req1_valid = 1'b1; ifa.req1_we = we; ifa.req1_wmask = m;
            ifa.req1_addr  = a;    ifa.req1_wdata = d;
        end else begin
            ifa.req0_valid = 1'b1; ifa.req0_we = we; ifa.req0_wmask = m;
            ifa.req0_addr  = a;    ifa.req0_wdata = d;
        end
    endtask

    task automatic reset_model();
        pq.delete();
        m_last = 1;
        m_rd0  = '0;
        m_rd1  = '0;
    endtask

    // One clock of dut_a: at the falling edge compare every output with the
    // model's view of this cycle, then advance the model and the clock.
    task automatic cycle_a();
        int                g;
        bit                rv0, rv1;
        pend_t             p;
        logic [48:0]       exp_bus, obs_bus;
        logic [AW-1:0]     ga;
        logic [NW-1:0]     gm;
        logic [DW-1:0]     gd;
        bit                gw;
        @(negedge soc_clk);
        if (ifa.req0_valid && ifa.req1_valid) g = (m_last == 1) ? 0 : 1;
        else if (ifa.req0_valid)              g = 0;
        else if (ifa.req1_valid)              g = 1;
        else                                  g = -1;
        gw = (g == 1) ? ifa.req1_we    : ifa.req0_we;
        gm = (g == 1) ? ifa.req1_wmask : ifa.req0_wmask;
        ga = (g == 1) ? ifa.req1_addr  : ifa.req0_addr;
        gd = (g == 1) ? ifa.req1_wdata : ifa.req0_wdata;

        rv0 = 1'b0;
        rv1 = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            if (p.id) begin
                rv1 = 1'b1;
                if (!p.we) m_rd1 = p.data;
            end else begin
                rv0 = 1'b1;
                if (!p.we) m_rd0 = p.data;
            end
        end

        obs_rdy  = {ifa.req1_ready, ifa.req0_ready};
        obs_resp = {ifa.resp1_valid, ifa.resp0_valid};
        n_checks++;
        if (obs_rdy !== {g == 1, g == 0}) begin
            n_fail++;
            $display("FAIL cyc=%0d ready{1,0}: got %b want %b", cyc, obs_rdy, {g == 1, g == 0});
        end

        if (g < 0) exp_bus = {1'b1, 1'b1, 4'h0, 11'h0, 32'h0};
        else       exp_bus = {1'b0, ~gw, gm, ga, gd};
        obs_bus = {ifa.soc_csb0, ifa.soc_web0, ifa.soc_wmask0, ifa.soc_addr0, ifa.soc_din0};
        n_checks++;
        if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("FAIL cyc=%0d sram_pins{csb,web,wmask,addr,din}: got %h want %h", cyc, obs_bus, exp_bus);
        end

        n_checks++;
        if (obs_resp !== {rv1, rv0}) begin
            n_fail++;
            $display("FAIL cyc=%0d resp_valid{1,0}: got %b want %b", cyc, obs_resp, {rv1, rv0});
        end

        n_checks++;
        if ({ifa.resp1_rdata, ifa.resp0_rdata} !== {m_rd1, m_rd0}) begin
            n_fail++;
            $display("FAIL cyc=%0d resp_rdata{1,0}: got %h_%h want %h_%h", cyc,
                     ifa.resp1_rdata, ifa.resp0_rdata, m_rd1, m_rd0);
        end

        if (g >= 0) begin
            pq.push_back('{due: cyc + 2, id: (g == 1), we: gw, data: shadow[ga]});
            if (gw)
                for (int b = 0; b < NW; b++)
                    if (gm[b]) shadow[ga][8*b +: 8] = gd[8*b +: 8];
            m_last = g;
        end
        cyc++;
        @(posedge soc_clk);
        #1;
    endtask

    task automatic apply_reset();
        soc_rst = 1'b1;
        idle_a();
        reset_model();
        repeat (2) @(posedge soc_clk);
        #1;
        soc_rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        soc_rst = 1'b1;
        idle_a();
        ifb.req0_valid = 1'b0;
        ifb.req1_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        reset_model();
        repeat (3) @(posedge soc_clk);
        #1;
        n_checks++;
        if ({ifa.resp1_valid, ifa.resp0_valid, ifb.resp1_valid, ifb.resp0_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_resp_valid: got %b want 0000",
                     {ifa.resp1_valid, ifa.resp0_valid, ifb.resp1_valid, ifb.resp0_valid});
        end
        n_checks++;
        if ({ifa.resp1_rdata, ifa.resp0_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_resp_rdata: got %h_%h want 0", ifa.resp1_rdata, ifa.resp0_rdata);
        end
        n_checks++;
        if ({ifa.soc_csb0, ifa.soc_web0, ifa.req1_ready, ifa.req0_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_idle_pins{csb,web,rdy1,rdy0}: got %b want 1100",
                     {ifa.soc_csb0, ifa.soc_web0, ifa.req1_ready, ifa.req0_ready});
        end
        soc_rst = 1'b0;
    endtask

    task automatic test_single_read();
        idle_a();
        drive_a(1'b0, 1'b0, 4'h0, 11'h005, 32'h0);
        cycle_a();
        idle_a();
        cycle_a();
        n_checks++;
        if ({ifa.resp1_valid, ifa.resp0_valid, ifa.resp0_rdata} !== {2'b01, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_read: got v=%b d=%h want v=01 d=deadbeef",
                     {ifa.resp1_valid, ifa.resp0_valid}, ifa.resp0_rdata);
        end
        repeat (2) cycle_a();
    endtask

    task automatic test_masked_write();
        idle_a();
        drive_a(1'b1, 1'b1, 4'b0011, 11'h200, 32'h12345678);
        cycle_a();
        idle_a();
        drive_a(1'b1, 1'b0, 4'h0, 11'h200, 32'h0);
        cycle_a();
        idle_a();
        n_checks++;
        if ({ifa.resp1_valid, ifa.resp0_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL write_ack: got %b want 10", {ifa.resp1_valid, ifa.resp0_valid});
        end
        cycle_a();
        n_checks++;
        if ({ifa.resp1_valid, ifa.resp1_rdata} !== {1'b1, 32'hAAAA5678}) begin
            n_fail++;
            $display("FAIL masked_readback: got v=%b d=%h want v=1 d=aaaa5678", ifa.resp1_valid, ifa.resp1_rdata);
        end
        repeat (2) cycle_a();
    endtask

    task automatic test_contention();
        int         exp_g[4] = '{0, 1, 0, 1};
        logic [1:0] exp_r[6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] got_r[6];
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            idle_a();
            if (k < 4) begin
                drive_a(1'b0, 1'b0, 4'h0, 11'(16 + k), 32'h0);
                drive_a(1'b1, 1'b0, 4'h0, 11'(32 + k), 32'h0);
            end
            cycle_a();
            got_r[k] = obs_resp;
            if (k < 4) begin
                n_checks++;
                if (obs_rdy !== ((exp_g[k] == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: got ready %b want grant to %0d", k, obs_rdy, exp_g[k]);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (got_r[k] !== exp_r[k]) begin
                n_fail++;
                $display("FAIL rr_resp_order[%0d]: got %b want %b", k, got_r[k], exp_r[k]);
            end
        end
        cycle_a();
    endtask

    task automatic test_read_then_write();
        logic [AW-1:0] a;
        logic [DW-1:0] old_d, new_d;
        a     = 11'h123;
        old_d = shadow[a];
        new_d = ~old_d ^ 32'h00FF00FF;
        idle_a(); drive_a(1'b0, 1'b0, 4'h0, a, 32'h0);  cycle_a();
        idle_a(); drive_a(1'b1, 1'b1, 4'hF, a, new_d);  cycle_a();
        n_checks++;
        if ({ifa.resp0_valid, ifa.resp0_rdata} !== {1'b1, old_d}) begin
            n_fail++;
            $display("FAIL read_before_write: got v=%b d=%h want v=1 d=%h", ifa.resp0_valid, ifa.resp0_rdata, old_d);
        end
        idle_a(); drive_a(1'b0, 1'b0, 4'h0, a, 32'h0);  cycle_a();
        idle_a(); cycle_a();
        n_checks++;
        if ({ifa.resp0_valid, ifa.resp0_rdata} !== {1'b1, new_d}) begin
            n_fail++;
            $display("FAIL read_after_write: got v=%b d=%h want v=1 d=%h", ifa.resp0_valid, ifa.resp0_rdata, new_d);
        end
        repeat (2) cycle_a();
    endtask

    task automatic test_streaming(input logic [AW-1:0] base);
        int first = -1;
        int count = 0;
        int last  = -1;
        for (int k = 0; k < 12; k++) begin
            idle_a();
            if (k < 8) drive_a(1'b0, 1'b0, 4'h0, base + 11'(k), 32'h0);
            cycle_a();
            if (obs_resp[0]) begin
                if (first < 0) first = k;
                last = k;
                count++;
            end
        end
        n_checks++;
        if (count != 8 || first != 2 || last != 9) begin
            n_fail++;
            $display("FAIL stream_%h: got %0d pulses in cycles %0d..%0d want 8 in 2..9", base, count, first, last);
        end
    endtask

    task automatic test_reset_midop();
        idle_a();
        drive_a(1'b0, 1'b0, 4'h0, 11'h005, 32'h0);
        cycle_a();
        idle_a();
        #2;
        soc_rst = 1'b1;
        #1;
        n_checks++;
        if ({ifa.resp1_valid, ifa.resp0_valid, ifa.soc_csb0, ifa.soc_web0} !== 4'b0011) begin
            n_fail++;
            $display("FAIL midop_reset_outputs{rv1,rv0,csb,web}: got %b want 0011",
                     {ifa.resp1_valid, ifa.resp0_valid, ifa.soc_csb0, ifa.soc_web0});
        end
        reset_model();
        repeat (2) @(posedge soc_clk);
        #1;
        soc_rst = 1'b0;
        repeat (4) cycle_a();
        drive_a(1'b0, 1'b0, 4'h0, 11'h001, 32'h0);
        drive_a(1'b1, 1'b0, 4'h0, 11'h002, 32'h0);
        cycle_a();
        n_checks++;
        if (obs_rdy !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_first_grant: got ready %b want 01", obs_rdy);
        end
        idle_a();
        repeat (3) cycle_a();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            idle_a();
            if ($urandom_range(0, 9) < 7)
                drive_a(1'b0, 1'($urandom), 4'($urandom), 11'($urandom), $urandom);
            if ($urandom_range(0, 9) < 7)
                drive_a(1'b1, 1'($urandom), 4'($urandom), 11'($urandom), $urandom);
            cycle_a();
        end
        idle_a();
        repeat (3) cycle_a();
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp_rdy, exp_resp;
        for (int k = 0; k < 8; k++) begin
            ifb.req0_valid = (k < 3);
            ifb.req0_we    = 1'b0; ifb.req0_wmask = 4'h0; ifb.req0_addr = 11'h031; ifb.req0_wdata = 32'h0;
            ifb.req1_valid = (k < 4);
            ifb.req1_we    = 1'b0; ifb.req1_wmask = 4'h0; ifb.req1_addr = 11'h041; ifb.req1_wdata = 32'h0;
            exp_rdy  = (k < 3) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00;
            exp_resp = (k >= 2 && k <= 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
            @(negedge soc_clk);
            n_checks++;
            if ({ifb.req1_ready, ifb.req0_ready} !== exp_rdy) begin
                n_fail++;
                $display("FAIL fixed_prio_ready[%0d]: got %b want %b", k, {ifb.req1_ready, ifb.req0_ready}, exp_rdy);
            end
            n_checks++;
            if ({ifb.resp1_valid, ifb.resp0_valid} !== exp_resp) begin
                n_fail++;
                $display("FAIL fixed_prio_resp[%0d]: got %b want %b", k, {ifb.resp1_valid, ifb.resp0_valid}, exp_resp);
            end
            if (k == 2 || k == 5) begin
                n_checks++;
                if ((k == 2 && ifb.resp0_rdata !== init_word('h031)) ||
                    (k == 5 && ifb.resp1_rdata !== init_word('h041))) begin
                    n_fail++;
                    $display("FAIL fixed_prio_data[%0d]: got %h_%h want %h_%h", k, ifb.resp1_rdata,
                             ifb.resp0_rdata, init_word('h041), init_word('h031));
                end
            end
            @(posedge soc_clk);
            #1;
        end
        ifb.req0_valid = 1'b0;
        ifb.req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_masked_write();
        test_contention();
        test_read_then_write();
        test_streaming(11'h000);
        test_streaming(11'h1FC);
        test_reset_midop();
        test_random();
        test_fixed_priority();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_port0_arbiter.md
Name: sram_port0_arbiter

Overview:
Two-requester arbiter sharing the read/write port 0 of the banked SoC SRAM wrapper, e.g. instruction fetch (req0) and data/bus master (req1). Each requester issues accepted read or write commands through a valid/ready handshake. The block grants one per cycle, round-robin or fixed-priority, and drives the wrapper's soc_*0 signals. It captures the synchronous read data and returns a registered response to the requester that issued the command. The SRAM port-0 clock is the same net as soc_clk.

Parameters:
NUM_WMASKS, 4, byte-enable count per word
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 11, word address width (matches wrapper soc_addr0)
ROUND_ROBIN, 1, 1 = round-robin on contention; 0 = fixed priority, req0 always wins

Ports:
soc_clk  input  1  system clock, also the SRAM port-0 clock
soc_rst  input  1  asynchronous reset, active-high
req0_valid  input  1  requester 0 command valid
req0_ready  output  1  requester 0 command accepted this cycle
req0_we  input  1  1 = write, 0 = read
req0_wmask  input  NUM_WMASKS  byte write enables
req0_addr  input  ADDR_WIDTH  word address
req0_wdata  input  DATA_WIDTH  write data
resp0_valid  output  1  one-cycle response pulse to requester 0
resp0_rdata  output  DATA_WIDTH  read data for requester 0
req1_valid / req1_ready / req1_we / req1_wmask / req1_addr / req1_wdata / resp1_valid / resp1_rdata  same as requester 0, for requester 1
soc_csb0  output  1  SRAM chip select, active-low
soc_web0  output  1  SRAM write enable, active-low
soc_wmask0  output  NUM_WMASKS  SRAM write mask
soc_addr0  output  ADDR_WIDTH  SRAM address
soc_din0  output  DATA_WIDTH  SRAM write data
soc_dout0  input  DATA_WIDTH  SRAM read data, valid the cycle after the read command

Behaviour:
- Reset, asynchronous: last_grant=1, so req0 wins the first contention. All pipeline valid bits are cleared. resp0_valid=resp1_valid=0 and resp0_rdata=resp1_rdata=0.
- Grant logic is combinational within the cycle.
  - Only one reqN_valid: that requester is granted.
  - Both valid with ROUND_ROBIN=1: grant the requester not equal to last_grant.
  - Both valid with ROUND_ROBIN=0: grant req0.
- reqN_ready = grant to N. There is never a cycle with both ready high. Ready never asserts without valid.
- last_grant updates at the clock edge whenever a grant occurs; it holds when idle.
- SRAM drive while granted, same cycle: soc_csb0=0, soc_web0=~reqN_we, and wmask/addr/din passed through from requester N.
- SRAM drive when idle: soc_csb0=1, soc_web0=1, soc_wmask0=0, soc_addr0=0, soc_din0=0.
- Read pipeline, for a command accepted in cycle T:
  - Stage-1 register (valid, requester id, we) is loaded at the end of T.
  - In T+1, if stage 1 is a read, soc_dout0 is captured into respN_rdata at the end of T+1.
  - respN_valid pulses high in T+2 for exactly one cycle.
  - Total latency is 2 cycles; throughput is 1 command per cycle with no bubbles.
- Writes: respN_valid also pulses in T+2 as the write acknowledge. respN_rdata is unchanged on a write.
- respN_rdata holds its last read value until the next read response to N.
- Responses cannot be back-pressured. Requesters must always accept them.
- Ordering: responses return in acceptance order. Interleaved grants produce interleaved pulses on resp0/resp1, never both in the same cycle.
- Back-to-back read then write to the same address: the read returns the pre-write data, following SRAM read-then-write ordering.
- Reset mid-operation: in-flight commands are dropped and no response pulse follows. The SRAM may already have committed an accepted write.
- Address width handling: addresses pass through unmodified. Bank selection is done downstream by the wrapper.

Test Plan:
- Single read: preload addr 0x005 = 0xDEADBEEF, req0 read at T → req0_ready=1 and soc_csb0=0 at T; resp0_valid=1 with resp0_rdata=0xDEADBEEF at T+2; resp1_valid stays 0.
- Masked write then read: req1 writes 0x12345678 with wmask=4'b0011 to addr 0x200 (initial 0xAAAAAAAA), then reads it → write ack at T+2, read returns 0xAAAA5678.
- Contention, ROUND_ROBIN=1: both valid for 4 cycles after reset → grant order 0,1,0,1; resp pulses alternate 0,1,0,1 starting 2 cycles after the first grant.
- Fixed priority, ROUND_ROBIN=0: both valid for 3 cycles → req0 granted all 3 cycles; req1_ready=0 throughout; req1 is granted in the first cycle req0_valid drops.
- Idle/reset: assert soc_rst while a read is in stage 1 → resp valid outputs 0 immediately, soc_csb0=1, soc_web0=1, no response pulse after reset release; first contention afterwards grants req0.
- Streaming: req0 issues 8 consecutive reads to addrs 0x000..0x007 crossing a bank boundary (0x1FF→0x200 in a second run) → 8 consecutive resp0_valid cycles with correct data in order.
